// File: rtl/sbox_sched_pkg.sv
// Shared types and default parameters for the masked S-box share scheduler.
// Optional build macro: SBOX_SYNCH_CHECK_EN (see sbox_share_scheduler).
package sbox_sched_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_SHARES  = 5;
    localparam int DEF_DATA_W  = 4;
    localparam int DEF_RAND_W  = 40;
    localparam int DEF_LATENCY = 4;

    // Wide enough to reach 2*LATENCY-1, the timeout threshold.
    function automatic int cnt_width(input int latency);
        return (2 * latency > 2) ? $clog2(2 * latency) : 1;
    endfunction

endpackage

// File: rtl/sbox_share_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, with wrap.
// Returns a one-hot winner and a flag that some requester is valid.
module rr_arbiter
    import sbox_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         gnt,
    output logic                       valid
);

    logic [NUM_REQ-1:0] hi;
    logic [NUM_REQ-1:0] src;

    always_comb begin
        hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            hi[i] = req[i] && (i >= int'(ptr));
        end
        // Fall back to the full vector when nothing sits at or above ptr.
        src   = (|hi) ? hi : req;
        gnt   = src & (~src + NUM_REQ'(1));
        valid = |req;
    end

endmodule

// File: rtl/sbox_share_scheduler.sv
// Time-shares one masked S-box between NUM_REQ requesters, round-robin.
// Define SBOX_SYNCH_CHECK_EN to complete on sbox_synch with a timeout.
module sbox_share_scheduler
    import sbox_sched_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int SHARES  = DEF_SHARES,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RAND_W  = DEF_RAND_W,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    output logic [NUM_REQ-1:0]                   req_ready,
    input  logic [NUM_REQ*SHARES*DATA_W-1:0]     req_data,
    input  logic                                 rnd_valid,
    output logic                                 rnd_ready,
    input  logic [RAND_W-1:0]                    rnd_data,
    output logic                                 sbox_rst,
    output logic [SHARES*DATA_W-1:0]             sbox_x,
    output logic [RAND_W-1:0]                    sbox_fresh,
    input  logic [SHARES*DATA_W-1:0]             sbox_y,
    input  logic                                 sbox_synch,
    output logic                                 rsp_valid,
    input  logic                                 rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]           rsp_id,
    output logic [SHARES*DATA_W-1:0]             rsp_data,
    output logic                                 rsp_err
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int SW = SHARES * DATA_W;
    localparam int CW = cnt_width(LATENCY);
    localparam logic [CW-1:0] CNT_DONE = CW'(LATENCY - 1);
`ifdef SBOX_SYNCH_CHECK_EN
    localparam logic [CW-1:0] CNT_TMO = CW'(2 * LATENCY - 1);
`else
    logic unused_synch;
    assign unused_synch = sbox_synch;
`endif

    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [IW-1:0] rr_ptr, cur_id, win_idx, ptr_next;
    logic [NUM_REQ-1:0] win_oh;
    logic [SW-1:0] sel_data;
    logic arb_valid, grant, fin, tmo;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .gnt   (win_oh),
        .valid (arb_valid)
    );

    always_comb begin
        win_idx  = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_oh[i]) begin
                win_idx  = IW'(i);
                sel_data = req_data[i*SW +: SW];
            end
        end
    end

    assign ptr_next = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + IW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        grant   = 1'b0;
        fin     = 1'b0;
        tmo     = 1'b0;
        unique case (state)
            IDLE: begin
                // Requester and PRNG handshakes only ever fire together.
                if (rst && arb_valid && rnd_valid) begin
                    grant   = 1'b1;
                    state_n = LOAD;
                end
            end
            LOAD: state_n = RUN;
            RUN: begin
`ifdef SBOX_SYNCH_CHECK_EN
                fin = sbox_synch;
                tmo = !sbox_synch && (cnt == CNT_TMO);
`else
                fin = (cnt == CNT_DONE);
`endif
                if (fin || tmo) state_n = DONE;
            end
            DONE: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign req_ready = win_oh & {NUM_REQ{grant}};
    assign rnd_ready = grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr     <= '0;
            cur_id     <= '0;
            cnt        <= '0;
            sbox_rst   <= 1'b0;
            sbox_x     <= '0;
            sbox_fresh <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
        end else begin
            sbox_rst <= grant;
            if (grant) begin
                sbox_x     <= sel_data;
                sbox_fresh <= rnd_data;
                cur_id     <= win_idx;
                rr_ptr     <= ptr_next;
            end
            if (state == LOAD)     cnt <= '0;
            else if (state == RUN) cnt <= cnt + CW'(1);
            if (fin) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_data  <= sbox_y;
            end
            if (tmo) begin
                rsp_valid <= 1'b1;
                rsp_id    <= cur_id;
                rsp_data  <= '0;
                rsp_err   <= 1'b1;
            end
            // Wipe operand and randomness shares once the result is taken.
            if (state == DONE && rsp_ready) begin
                rsp_valid  <= 1'b0;
                rsp_err    <= 1'b0;
                sbox_x     <= '0;
                sbox_fresh <= '0;
            end
        end
    end

endmodule
